// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory responder: word type, I/O map offsets
// and the responder state encoding.
package memory_responder_pkg;

    localparam int unsigned WordWidth = 16;
    typedef logic [WordWidth-1:0] word_t;

    localparam word_t IoBaseDefault = 16'hFFF0;

    // Word offsets within the I/O window
    localparam word_t IoOffsetLed     = 16'd0;
    localparam word_t IoOffsetSwitch  = 16'd1;
    localparam word_t IoOffsetCounter = 16'd2;

    typedef enum logic [1:0] {
        StIdle               = 2'd0,
        StRespondData        = 2'd1,
        StRespondInstruction = 2'd2
    } state_e;

endpackage

// File: rtl/memory_responder_if.sv
// CPU-side bus of the memory responder: instruction-fetch port and data port.
interface memory_responder_if;
    import memory_responder_pkg::*;

    logic  instruction_request;
    word_t instruction_address;
    word_t instruction_read_data;
    logic  instruction_valid;

    logic  data_request;
    logic  data_write_enable;
    word_t data_address;
    word_t data_write_data;
    word_t data_read_data;
    logic  data_valid;

    modport master (
        output instruction_request, instruction_address,
        output data_request, data_write_enable, data_address, data_write_data,
        input  instruction_read_data, instruction_valid,
        input  data_read_data, data_valid
    );

    modport slave (
        input  instruction_request, instruction_address,
        input  data_request, data_write_enable, data_address, data_write_data,
        output instruction_read_data, instruction_valid,
        output data_read_data, data_valid
    );

endinterface

// File: rtl/memory_responder_io_registers.sv
// Memory-mapped I/O registers: LED register, free-running cycle counter and the
// I/O read mux. Offsets are relative to the start of the I/O window.
module memory_responder_io_registers
    import memory_responder_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  write_i,
    input  word_t offset_i,
    input  word_t wdata_i,
    input  word_t switches_i,
    output word_t leds_o,
    output word_t rdata_o
);

    word_t leds_q, leds_d;
    word_t counter_q, counter_d;

    always_comb begin
        leds_d    = leds_q;
        counter_d = counter_q + 16'd1;
        if (write_i) begin
            if (offset_i == IoOffsetLed) begin
                leds_d = wdata_i;
            end
            // A clearing write overrides this cycle's increment
            if (offset_i == IoOffsetCounter) begin
                counter_d = '0;
            end
        end
    end

    // Counter reads return the value it takes at the accept edge
    always_comb begin
        case (offset_i)
            IoOffsetLed:     rdata_o = leds_q;
            IoOffsetSwitch:  rdata_o = switches_i;
            IoOffsetCounter: rdata_o = counter_d;
            default:         rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            leds_q    <= '0;
            counter_q <= '0;
        end else begin
            leds_q    <= leds_d;
            counter_q <= counter_d;
        end
    end

    assign leds_o = leds_q;

endmodule

// File: rtl/memory_responder.sv
// Memory responder: arbitrates the CPU fetch and data ports onto one single-port
// synchronous RAM and decodes an I/O window at the top of the address map.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 14,
    parameter word_t       IO_BASE       = IoBaseDefault
) (
    input  logic                     clock,
    input  logic                     reset,
    memory_responder_if.slave        bus,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     ram_write_enable,
    output word_t                    ram_write_data,
    input  word_t                    ram_read_data,
    input  word_t                    switches,
    output word_t                    leds
);

    localparam int unsigned RamWords = 1 << ADDRESS_WIDTH;

    state_e state_q, state_d;
    logic   data_valid_q, data_valid_d;
    logic   instr_valid_q, instr_valid_d;
    logic   from_ram_q, from_ram_d;
    word_t  resp_q, resp_d;
    word_t  data_hold_q, data_hold_d;
    word_t  instr_hold_q, instr_hold_d;

    logic   idle, accept_data, accept_instr;
    logic   is_io, is_ram, io_write;
    word_t  acc_addr, io_offset, io_rdata;
    word_t  data_rsp, instr_rsp;

    always_comb begin
        idle         = (state_q == StIdle);
        accept_data  = idle && bus.data_request;
        accept_instr = idle && !bus.data_request && bus.instruction_request;
        acc_addr     = bus.data_request ? bus.data_address : bus.instruction_address;
        is_io        = (acc_addr >= IO_BASE);
        is_ram       = !is_io && (32'(acc_addr) < RamWords);
        io_offset    = acc_addr - IO_BASE;
        io_write     = accept_data && bus.data_write_enable && is_io;
    end

    assign ram_address      = acc_addr[ADDRESS_WIDTH-1:0];
    assign ram_write_enable = !reset && accept_data && bus.data_write_enable && is_ram;
    assign ram_write_data   = bus.data_write_data;

    // RAM data only exists during the respond cycle; everything else comes from resp_q
    always_comb begin
        data_rsp  = data_hold_q;
        instr_rsp = instr_hold_q;
        if (state_q == StRespondData) begin
            data_rsp = from_ram_q ? ram_read_data : resp_q;
        end
        if (state_q == StRespondInstruction) begin
            instr_rsp = from_ram_q ? ram_read_data : resp_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        data_valid_d  = 1'b0;
        instr_valid_d = 1'b0;
        from_ram_d    = from_ram_q;
        resp_d        = resp_q;
        data_hold_d   = data_hold_q;
        instr_hold_d  = instr_hold_q;
        unique case (state_q)
            StIdle: begin
                if (accept_data) begin
                    state_d      = StRespondData;
                    data_valid_d = 1'b1;
                    from_ram_d   = is_ram && !bus.data_write_enable;
                    // Writes leave the visible load data unchanged
                    if (bus.data_write_enable) begin
                        resp_d = data_hold_q;
                    end else if (is_io) begin
                        resp_d = io_rdata;
                    end else begin
                        resp_d = '0;
                    end
                end else if (accept_instr) begin
                    state_d       = StRespondInstruction;
                    instr_valid_d = 1'b1;
                    from_ram_d    = is_ram;
                    resp_d        = '0;
                end
            end
            StRespondData: begin
                state_d     = StIdle;
                data_hold_d = data_rsp;
            end
            StRespondInstruction: begin
                state_d      = StIdle;
                instr_hold_d = instr_rsp;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            data_valid_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            from_ram_q    <= 1'b0;
            resp_q        <= '0;
            data_hold_q   <= '0;
            instr_hold_q  <= '0;
        end else begin
            state_q       <= state_d;
            data_valid_q  <= data_valid_d;
            instr_valid_q <= instr_valid_d;
            from_ram_q    <= from_ram_d;
            resp_q        <= resp_d;
            data_hold_q   <= data_hold_d;
            instr_hold_q  <= instr_hold_d;
        end
    end

    assign bus.data_valid            = data_valid_q;
    assign bus.instruction_valid     = instr_valid_q;
    assign bus.data_read_data        = data_rsp;
    assign bus.instruction_read_data = instr_rsp;

    memory_responder_io_registers u_io_registers (
        .clk_i      (clock),
        .rst_i      (reset),
        .write_i    (io_write),
        .offset_i   (io_offset),
        .wdata_i    (bus.data_write_data),
        .switches_i (switches),
        .leds_o     (leds),
        .rdata_o    (io_rdata)
    );

endmodule
